cdc_toggle_channel_arbiter: RTL and testbench
=============================================

# cdc_toggle_channel_arbiter

Shares one toggle-handshake clock-domain-crossing channel between `N_REQ` local requesters. Round-robin arbitration picks a requester, latches its word onto a held-stable data bus and flips the outgoing request toggle. The block then waits for the far domain's acknowledge toggle, synchronised through `sync2_toggle_to_pulse`, before it accepts the next word. It sits on the launching side of every multi-bit control crossing in the design.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 8: width of one word.
- `TIMEOUT_CYCLES`, 255: acknowledge watchdog limit. Used only with `CDC_ARB_TIMEOUT_EN`.

- `clk`  in  1  the only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester word valid.
- `req_data`  in  N_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W].
- `req_ready`  out  N_REQ  one-hot acceptance; combinational.
- `xfer_toggle`  out  1  request toggle to the far domain; registered.
- `xfer_data`  out  DATA_W  latched word; stable from launch until the acknowledge.
- `xfer_src`  out  clog2(N_REQ)  index of the granted requester; registered.
- `ack_toggle`  in  1  far-domain acknowledge toggle; asynchronous to `clk`.
- `busy`  out  1  high while in WAIT_ACK.
- `done`  out  1  one-cycle pulse on acknowledge receipt; combinational from the synchronised pulse.
- `proto_err`  out  1  sticky: an acknowledge pulse arrived while IDLE.
- `timeout_err`  out  1  sticky watchdog flag. Constant 0 when the macro is undefined.

## Operation
- Reset values:
  - `xfer_toggle`=0, `xfer_data`=0, `xfer_src`=0.
  - Round-robin pointer `last`=N_REQ-1, so requester 0 has first priority.
  - State IDLE; `busy`, `proto_err`, `timeout_err` all 0.
  - The synchroniser's stages are also 0. The far side must reset its acknowledge toggle to 0.
- Arbitration:
  - Search order is `last`+1, `last`+2, … modulo N_REQ. The first requester with `req_valid` set wins.
- IDLE:
  - If any valid is set, `req_ready[g]`=1 for the winner g only, in that same cycle.
  - At the clock edge: `xfer_data`<=word g, `xfer_src`<=g, `xfer_toggle` inverts, `last`<=g, state<=WAIT_ACK.
- WAIT_ACK:
  - `req_ready`=0 and `busy`=1.
  - On an acknowledge pulse, `done`=1 in that cycle and state<=IDLE at the next edge. The next grant is possible in the following cycle.
- Requesters must hold `req_valid` and data until ready. Dropping valid before the grant is legal; the requester is simply skipped.
- An acknowledge pulse while IDLE sets `proto_err`. It causes no state change and no `done`.
- A reset mid-transfer returns everything to reset values. The far side must be reset together with this block, otherwise the toggle phases diverge.

## Timing
- Grant to toggle flip: 0 cycles for ready (combinational), 1 edge for `xfer_toggle`/`xfer_data`.
- `ack_toggle` change to `done`:
  - The 2-flop synchroniser output changes at the 2nd edge after the change.
  - `done` is high for the following cycle.
  - Plus up to 1 cycle of metastability uncertainty.
- Minimum spacing between launches: 1 (launch) + far-domain turnaround + 2..3 sync cycles + 1 (return to IDLE).
- `busy` rises the cycle after the grant and falls the cycle after `done`.

## Configuration
- `CDC_ARB_TIMEOUT_EN` defined:
  - An 8..16-bit counter clears at launch and increments each WAIT_ACK cycle, saturating.
  - When it reaches `TIMEOUT_CYCLES`, sticky `timeout_err`=1.
  - The transfer is not aborted; the block keeps waiting so the toggle phase stays consistent.
- Undefined: no counter, and `timeout_err` is tied to 0.

## Structure
- Shared package `cdc_arb_pkg`:
  - State enum IDLE/WAIT_ACK.
  - Index-width helper function.
  - Default `TIMEOUT_CYCLES` constant.
- One sub-module: an `sync2_toggle_to_pulse` instance on `ack_toggle`. Its `pulse` output is the acknowledge event.
- The round-robin search is a local function, not a separate module.

## Test plan
- Reset release, `req_valid`=4'b0100, data2=8'hA5 -> `req_ready`=4'b0100 the same cycle. Next cycle: `xfer_toggle`=1, `xfer_data`=A5, `xfer_src`=2, `busy`=1.
- Toggle `ack_toggle` -> `done` high exactly one cycle, 2..3 cycles later. IDLE next; `xfer_data` unchanged until the next grant.
- All four valid and held, acknowledge echoed each time -> grant order 0,1,2,3,0. No requester granted twice in a row.
- `ack_toggle` flipped while IDLE -> `proto_err`=1 and stays set; no `done`, no state change.
- Reset asserted during WAIT_ACK -> all outputs at reset values immediately (asynchronous); requester 0 wins the first grant afterwards.
- Macro defined, `TIMEOUT_CYCLES`=20, acknowledge withheld -> `timeout_err`=1 at WAIT_ACK cycle 20. A late acknowledge still produces `done`. With the macro undefined, `timeout_err`=0 throughout.

Source files
------------

// File: rtl/cdc_arb_pkg.sv
// cdc_arb_pkg: shared state enum, index-width helper and watchdog default for the CDC arbiter.
package cdc_arb_pkg;
  typedef enum logic {IDLE, WAIT_ACK} state_t;
  localparam int TIMEOUT_DEFAULT = 255;
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/sync2_toggle_to_pulse.sv
// sync2_toggle_to_pulse: two-flop synchroniser on a toggle, plus an edge stage emitting a one-cycle pulse.
module sync2_toggle_to_pulse (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);
  logic [2:0] s;
  always_ff @(posedge clk or negedge rst)
    if (!rst) s <= '0;
    else s <= {s[1:0], d};
  assign pulse = s[2] ^ s[1];
endmodule

// File: rtl/cdc_toggle_channel_arbiter.sv
// cdc_toggle_channel_arbiter: round-robin share of one toggle-handshake CDC channel; watchdog under CDC_ARB_TIMEOUT_EN.
module cdc_toggle_channel_arbiter
  import cdc_arb_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      xfer_toggle,
  output logic [DATA_W-1:0]         xfer_data,
  output logic [idx_w(N_REQ)-1:0]   xfer_src,
  input  logic                      ack_toggle,
  output logic                      busy,
  output logic                      done,
  output logic                      proto_err,
  output logic                      timeout_err
);
  localparam int IW = idx_w(N_REQ);
  localparam logic [N_REQ-1:0] ONE = 1;
  function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] v, input logic [IW-1:0] l);
    int j;
    rr_pick = l;
    for (int k = N_REQ; k >= 1; k--) begin
      j = (int'(l) + k) % N_REQ;
      if (v[j]) rr_pick = IW'(j);
    end
  endfunction
  state_t state, state_nx;
  logic [IW-1:0] last, g;
  logic launch, ack;
  sync2_toggle_to_pulse u_sync (.clk(clk), .rst(rst), .d(ack_toggle), .pulse(ack));
  assign g = rr_pick(req_valid, last);
  assign launch = (state == IDLE) && |req_valid;
  assign busy = (state == WAIT_ACK);
  assign done = busy && ack;
  assign req_ready = launch ? ONE << g : '0;
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (launch ? WAIT_ACK : IDLE) : (ack ? IDLE : WAIT_ACK);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      xfer_toggle <= 1'b0;
      xfer_data   <= '0;
      xfer_src    <= '0;
      last        <= IW'(N_REQ - 1);
      proto_err   <= 1'b0;
    end else begin
      if (launch) begin
        xfer_toggle <= ~xfer_toggle;
        xfer_data   <= req_data[g*DATA_W +: DATA_W];
        xfer_src    <= g;
        last        <= g;
      end
      if (!busy && ack) proto_err <= 1'b1;
    end
`ifdef CDC_ARB_TIMEOUT_EN
  // cnt holds the number of the current WAIT_ACK cycle, so the flag is up in cycle TIMEOUT_CYCLES
  logic [15:0] cnt;
  logic terr;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt  <= '0;
      terr <= 1'b0;
    end else begin
      if (launch) cnt <= 16'd1;
      else if (busy && cnt != '1) cnt <= cnt + 16'd1;
      if (busy && int'(cnt) >= TIMEOUT_CYCLES - 1) terr <= 1'b1;
    end
  assign timeout_err = terr;
`else
  assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_cdc_toggle_channel_arbiter.sv
// tb_cdc_toggle_channel_arbiter: randomized round-robin CDC arbiter bench with a behavioural grant model.
module tb_cdc_toggle_channel_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  logic clk = 0;
  logic rst = 0;
  logic [N-1:0] req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0] req_ready;
  logic xfer_toggle;
  logic [W-1:0] xfer_data;
  logic [1:0] xfer_src;
  logic ack_toggle = 0;
  logic busy, done, proto_err, timeout_err;
  int checks = 0;
  int failures = 0;
  int last_m = N - 1;
  logic tog_m = 0;

  cdc_toggle_channel_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .xfer_toggle(xfer_toggle), .xfer_data(xfer_data), .xfer_src(xfer_src), .ack_toggle(ack_toggle),
    .busy(busy), .done(done), .proto_err(proto_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic int rr_model(input logic [N-1:0] v, input int last);
    for (int i = 1; i <= N; i++)
      if (v[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  task automatic do_ack(output int lat, output int highs);
    lat = -1;
    highs = 0;
    ack_toggle = ~ack_toggle;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (done) begin
        highs++;
        if (lat < 0) lat = n;
      end
    end
  endtask

  task automatic test_reset;
    rst = 0;
    #1;
    checks++;
    if ({xfer_toggle, xfer_data, xfer_src, busy, done, proto_err, timeout_err, req_ready} !== '0) begin
      failures++;
      $display("FAIL reset_state: got tog=%b data=%h src=%0d busy=%b done=%b perr=%b terr=%b ready=%b, want all 0",
               xfer_toggle, xfer_data, xfer_src, busy, done, proto_err, timeout_err, req_ready);
    end
    @(negedge clk);
    rst = 1;
    last_m = N - 1;
    tog_m = 0;
  endtask

  task automatic test_basic;
    int lat, highs;
    req_valid = 4'b0100;
    req_data = '0;
    req_data[2*W +: W] = 8'hA5;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL basic_ready: got %b want 0100", req_ready);
    end
    @(negedge clk);
    tog_m = ~tog_m;
    last_m = 2;
    req_valid = '0;
    checks++;
    if ({xfer_toggle, xfer_data, xfer_src, busy} !== {1'b1, 8'hA5, 2'd2, 1'b1}) begin
      failures++;
      $display("FAIL basic_launch: got tog=%b data=%h src=%0d busy=%b want 1 a5 2 1",
               xfer_toggle, xfer_data, xfer_src, busy);
    end
    do_ack(lat, highs);
    checks++;
    if (!(lat inside {[2:3]}) || highs != 1) begin
      failures++;
      $display("FAIL basic_done: latency=%0d highs=%0d want latency 2..3 highs 1", lat, highs);
    end
    checks++;
    if (busy !== 1'b0 || xfer_data !== 8'hA5) begin
      failures++;
      $display("FAIL basic_idle: busy=%b data=%h want 0 a5", busy, xfer_data);
    end
  endtask

  task automatic test_round_robin;
    logic [N-1:0] v;
    logic [N*W-1:0] d;
    int exp, lat, highs;
    for (int r = 0; r < 17; r++) begin
      v = (r < 5) ? 4'hF : N'($urandom);
      d = {$urandom, $urandom};
      req_valid = v;
      req_data = d;
      #1;
      exp = rr_model(v, last_m);
      checks++;
      if (req_ready !== ((exp < 0) ? 4'b0 : 4'b1 << exp)) begin
        failures++;
        $display("FAIL rr_ready[%0d]: valid=%b got %b want winner %0d", r, v, req_ready, exp);
      end
      @(negedge clk);
      if (exp >= 0) begin
        tog_m = ~tog_m;
        last_m = exp;
        checks++;
        if ({xfer_toggle, xfer_data, xfer_src, busy, req_ready} !== {tog_m, d[exp*W +: W], 2'(exp), 1'b1, 4'b0}) begin
          failures++;
          $display("FAIL rr_launch[%0d]: got tog=%b data=%h src=%0d busy=%b ready=%b want tog=%b data=%h src=%0d busy=1 ready=0",
                   r, xfer_toggle, xfer_data, xfer_src, busy, req_ready, tog_m, d[exp*W +: W], exp);
        end
        req_valid = '0;
        do_ack(lat, highs);
        checks++;
        if (!(lat inside {[2:3]}) || highs != 1 || busy !== 1'b0) begin
          failures++;
          $display("FAIL rr_ack[%0d]: latency=%0d highs=%0d busy=%b want 2..3 1 0", r, lat, highs, busy);
        end
      end else begin
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL rr_nolaunch[%0d]: busy=%b want 0", r, busy);
        end
      end
    end
  endtask

  task automatic test_proto_err;
    int lat, highs, exp;
    do_ack(lat, highs);
    checks++;
    if (highs != 0 || proto_err !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL proto_idle: highs=%0d perr=%b busy=%b want 0 1 0", highs, proto_err, busy);
    end
    req_valid = 4'b1010;
    exp = rr_model(req_valid, last_m);
    @(negedge clk);
    tog_m = ~tog_m;
    last_m = exp;
    req_valid = '0;
    do_ack(lat, highs);
    checks++;
    if (proto_err !== 1'b1 || highs != 1 || xfer_src !== 2'(exp)) begin
      failures++;
      $display("FAIL proto_sticky: perr=%b highs=%0d src=%0d want 1 1 %0d", proto_err, highs, xfer_src, exp);
    end
  endtask

  task automatic test_timeout;
    int lat, highs;
    logic seen = 0;
    req_valid = 4'b0001;
    last_m = rr_model(req_valid, last_m);
    @(negedge clk);
    tog_m = ~tog_m;
    req_valid = '0;
    for (int c = 2; c <= 30; c++) begin
      @(negedge clk);
      seen |= timeout_err;
`ifdef CDC_ARB_TIMEOUT_EN
      if (c == 19 || c == 20) begin
        checks++;
        if (timeout_err !== (c == 20)) begin
          failures++;
          $display("FAIL timeout_cycle%0d: got %b want %b", c, timeout_err, c == 20);
        end
      end
`endif
    end
`ifndef CDC_ARB_TIMEOUT_EN
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL timeout_disabled: timeout_err rose, want 0 throughout");
    end
`endif
    do_ack(lat, highs);
    checks++;
    if (highs != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_late_ack: highs=%0d busy=%b want 1 0", highs, busy);
    end
  endtask

  task automatic test_reset_mid;
    int lat, highs;
    req_valid = 4'b1000;
    req_data = {$urandom, $urandom};
    @(negedge clk);
    req_valid = '0;
    #2;
    rst = 0;
    ack_toggle = 0;
    #1;
    checks++;
    if ({xfer_toggle, xfer_data, xfer_src, busy, done, proto_err, timeout_err} !== '0) begin
      failures++;
      $display("FAIL reset_mid: got tog=%b data=%h src=%0d busy=%b done=%b perr=%b terr=%b want all 0",
               xfer_toggle, xfer_data, xfer_src, busy, done, proto_err, timeout_err);
    end
    @(negedge clk);
    rst = 1;
    last_m = N - 1;
    tog_m = 0;
    req_valid = 4'hF;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL reset_mid_grant: got %b want 0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    tog_m = ~tog_m;
    last_m = 0;
    checks++;
    if (xfer_src !== 2'd0 || xfer_toggle !== tog_m || xfer_data !== req_data[W-1:0]) begin
      failures++;
      $display("FAIL reset_mid_launch: src=%0d tog=%b data=%h want 0 %b %h", xfer_src, xfer_toggle, xfer_data, tog_m, req_data[W-1:0]);
    end
    do_ack(lat, highs);
    checks++;
    if (highs != 1 || proto_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_ack: highs=%0d perr=%b want 1 0", highs, proto_err);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_basic;
    test_round_robin;
    test_proto_err;
    test_timeout;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
